// File: rtl/prio_encoder_32x5_seq_pkg.sv
// Shared definitions for the sequential 32-to-5 priority encoder.
//   N     : number of request lines
//   W     : code width, clog2(N)
//   ofsm_e: output-stage state (EMPTY holds nothing, FULL holds a code)
package prio_encoder_32x5_seq_pkg;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

  localparam int N = 32;
  localparam int W = clog2(N);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ofsm_e;

endpackage

// File: rtl/prio_encoder_32x5_seq_enc.sv
// Combinational 32-to-5 priority encoder; the highest set bit wins.
//   in  : 32 candidate lines
//   idx : index of the highest set line (0 when none set)
//   any : at least one line is set
module prio_enc_32x5
  import prio_encoder_32x5_seq_pkg::*;
(
  input  logic [31:0] in,
  output logic [4:0]  idx,
  output logic        any
);

  // Ascending scan so the last (highest) set bit overrides earlier ones.
  function automatic logic [3:0] enc16(input logic [15:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

  logic       any_hi;
  logic       any_lo;
  logic [3:0] idx_hi;
  logic [3:0] idx_lo;

  always_comb begin
    any_hi = |in[31:16];
    any_lo = |in[15:0];
    idx_hi = enc16(in[31:16]);
    idx_lo = enc16(in[15:0]);
    any    = any_hi | any_lo;
    // Upper half has strict priority over the lower half.
    idx    = any_hi ? {1'b1, idx_hi} : {1'b0, idx_lo};
  end

endmodule

// File: rtl/prio_encoder_32x5_seq.sv
// Sequential 32-to-5 priority encoder with sticky pending set and a
// registered valid/ready output stage.
//   clock, reset_b : clock, asynchronous active-low reset
//   en, req        : capture enable and request pulses (sticky into pend)
//   code, valid    : granted index and its qualifier
//   ready          : consumer accepts code when valid & ready
//   pend           : registered pending set
//   overrun, clr_ovr : sticky "request hit an already-pending line" flag and its clear
module prio_encoder_32x5_seq
  import prio_encoder_32x5_seq_pkg::*;
(
  input  logic         clock,
  input  logic         reset_b,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [W-1:0] code,
  output logic         valid,
  input  logic         ready,
  output logic [N-1:0] pend,
  output logic         overrun,
  input  logic         clr_ovr
);

  ofsm_e        state_q;
  logic [W-1:0] code_q;
  logic [N-1:0] pend_q;
  logic         ovr_q;

  logic [N-1:0] pend_d;
  logic         ovr_d;
  logic [N-1:0] req_en;
  logic [N-1:0] claim_mask;
  logic [W-1:0] enc_idx;
  logic         enc_any;
  logic         load;

  // Encoder looks at the registered pending set only, never raw req.
  prio_enc_32x5 u_enc (
    .in  (pend_q),
    .idx (enc_idx),
    .any (enc_any)
  );

  always_comb begin
    req_en = en ? req : '0;
    // The stage takes a new code when empty, or when the current one is
    // accepted and something is still pending (back-to-back reload).
    load       = enc_any && ((state_q == EMPTY) || ready);
    claim_mask = load ? (N'(1) << enc_idx) : '0;
    // Clear the claimed bit first, then OR in arrivals so a set wins.
    pend_d = (pend_q & ~claim_mask) | req_en;
    // Set has priority over clr_ovr.
    ovr_d  = (|(req_en & pend_q & ~claim_mask)) | (ovr_q & ~clr_ovr);
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= EMPTY;
      code_q  <= '0;
      pend_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
      case (state_q)
        EMPTY: begin
          if (load) begin
            code_q  <= enc_idx;
            state_q <= FULL;
          end
        end
        FULL: begin
          if (load) begin
            code_q <= enc_idx;
          end else if (ready) begin
            state_q <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign code    = code_q;
  assign valid   = (state_q == FULL);
  assign pend    = pend_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_prio_encoder_32x5_seq.sv
module tb_prio_encoder_32x5_seq;

  logic        clock;
  logic        reset_b;
  logic        en;
  logic [31:0] req;
  logic [4:0]  code;
  logic        valid;
  logic        ready;
  logic [31:0] pend;
  logic        overrun;
  logic        clr_ovr;

  int vectors;
  int miscompares;
  bit chk_on;

  prio_encoder_32x5_seq dut (
    .clock   (clock),
    .reset_b (reset_b),
    .en      (en),
    .req     (req),
    .code    (code),
    .valid   (valid),
    .ready   (ready),
    .pend    (pend),
    .overrun (overrun),
    .clr_ovr (clr_ovr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: pending set as a plain bit vector, grant = highest
  // pending index, one grant per cycle while the consumer keeps up.
  logic [31:0] m_pend;
  logic        m_valid;
  logic [4:0]  m_code;
  logic        m_ovr;

  always @(posedge clock or negedge reset_b) begin : model
    int          g;
    logic [31:0] kept;
    logic [31:0] arrive;
    if (!reset_b) begin
      m_pend  <= '0;
      m_valid <= 1'b0;
      m_code  <= '0;
      m_ovr   <= 1'b0;
    end else begin
      arrive = en ? req : 32'h0;
      g = -1;
      if (m_pend != 32'h0 && (!m_valid || ready)) begin
        for (int i = 0; i < 32; i++) if (m_pend[i]) g = i;
      end
      kept = m_pend;
      if (g >= 0) kept[g] = 1'b0;
      m_pend <= kept | arrive;
      if (g >= 0) begin
        m_valid <= 1'b1;
        m_code  <= 5'(g);
      end else if (m_valid && ready) begin
        m_valid <= 1'b0;
      end
      m_ovr <= ((arrive & kept) != 32'h0) || (m_ovr && !clr_ovr);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Literal expectation applied to both the DUT and the model.
  task automatic lit(input string nm, input logic [31:0] d, input logic [31:0] m,
                     input logic [31:0] exp);
    check({nm, "_dut"}, d, exp);
    check({nm, "_model"}, m, exp);
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (chk_on) begin
      check("valid", 32'(valid), 32'(m_valid));
      check("pend", pend, m_pend);
      check("overrun", 32'(overrun), 32'(m_ovr));
      if (m_valid) check("code", 32'(code), 32'(m_code));
    end
  end

  task automatic pe();
    @(posedge clock);
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    chk_on = 1'b0;
    reset_b = 1'b0;
    en = 1'b0;
    req = '0;
    ready = 1'b0;
    clr_ovr = 1'b0;
    pe();
    pe();
    reset_b = 1'b1;
    chk_on = 1'b1;
    lit("rst_pend", pend, m_pend, 0);
    lit("rst_valid", 32'(valid), 32'(m_valid), 0);
    lit("rst_code", 32'(code), 32'(m_code), 0);
    lit("rst_ovr", 32'(overrun), 32'(m_ovr), 0);

    // Single request
    en = 1'b1; ready = 1'b1; req = 32'h0000_0400;
    pe(); lit("single_pend", pend, m_pend, 32'h400);
    lit("single_v0", 32'(valid), 32'(m_valid), 0);
    req = '0;
    pe(); lit("single_code", 32'(code), 32'(m_code), 10);
    lit("single_v1", 32'(valid), 32'(m_valid), 1);
    lit("single_pend0", pend, m_pend, 0);
    pe(); lit("single_v2", 32'(valid), 32'(m_valid), 0);

    // Priority drain, no bubble
    req = 32'h8000_0011;
    pe(); lit("drain_pend", pend, m_pend, 32'h8000_0011);
    req = '0;
    pe(); lit("drain_c31", 32'(code), 32'(m_code), 31);
    pe(); lit("drain_c4", 32'(code), 32'(m_code), 4);
    lit("drain_v4", 32'(valid), 32'(m_valid), 1);
    pe(); lit("drain_c0", 32'(code), 32'(m_code), 0);
    lit("drain_v0", 32'(valid), 32'(m_valid), 1);
    pe(); lit("drain_end", 32'(valid), 32'(m_valid), 0);

    // Backpressure
    ready = 1'b0; req = 32'h0000_0003;
    pe(); req = '0;
    pe();
    for (int k = 0; k < 5; k++) begin
      lit("bp_code", 32'(code), 32'(m_code), 1);
      lit("bp_pend", pend, m_pend, 32'h1);
      pe();
    end
    ready = 1'b1;
    pe(); lit("bp_c0", 32'(code), 32'(m_code), 0);
    lit("bp_v", 32'(valid), 32'(m_valid), 1);
    pe(); lit("bp_end", 32'(valid), 32'(m_valid), 0);

    // Set wins over claim
    req = 32'h80;
    pe(); req = 32'h80;
    pe(); lit("sw_c7a", 32'(code), 32'(m_code), 7);
    lit("sw_pend", pend, m_pend, 32'h80);
    lit("sw_ovr", 32'(overrun), 32'(m_ovr), 0);
    req = '0;
    pe(); lit("sw_c7b", 32'(code), 32'(m_code), 7);
    lit("sw_v", 32'(valid), 32'(m_valid), 1);
    pe(); lit("sw_end", 32'(valid), 32'(m_valid), 0);

    // Overrun while held
    ready = 1'b0; req = 32'h80;
    pe(); pe();
    lit("ov_pre", 32'(overrun), 32'(m_ovr), 0);
    pe(); lit("ov_set", 32'(overrun), 32'(m_ovr), 1);
    req = '0;
    pe(); lit("ov_hold", 32'(overrun), 32'(m_ovr), 1);
    clr_ovr = 1'b1;
    pe(); lit("ov_clr", 32'(overrun), 32'(m_ovr), 0);
    clr_ovr = 1'b0; ready = 1'b1;
    pe(); lit("ov_c7", 32'(code), 32'(m_code), 7);
    pe(); lit("ov_end", 32'(valid), 32'(m_valid), 0);

    // en gating, then full 32-line drain
    en = 1'b0; req = 32'hFFFF_FFFF;
    pe(); pe();
    lit("en_pend", pend, m_pend, 0);
    lit("en_valid", 32'(valid), 32'(m_valid), 0);
    en = 1'b1;
    pe(); lit("en_pend1", pend, m_pend, 32'hFFFF_FFFF);
    req = '0;
    pe(); lit("all_c31", 32'(code), 32'(m_code), 31);
    for (int k = 30; k >= 0; k--) begin
      pe(); lit("all_ck", 32'(code), 32'(m_code), 32'(k));
    end
    pe(); lit("all_end", 32'(valid), 32'(m_valid), 0);

    // Asynchronous reset mid-operation
    ready = 1'b0; req = 32'h8000_0001;
    pe(); req = '0;
    pe(); req = 32'h8000_0001;
    pe(); req = '0;
    lit("ar_pend", pend, m_pend, 32'h8000_0001);
    lit("ar_valid", 32'(valid), 32'(m_valid), 1);
    #2 reset_b = 1'b0;
    #1;
    lit("ar_pend0", pend, m_pend, 0);
    lit("ar_valid0", 32'(valid), 32'(m_valid), 0);
    lit("ar_code0", 32'(code), 32'(m_code), 0);
    lit("ar_ovr0", 32'(overrun), 32'(m_ovr), 0);
    pe(); reset_b = 1'b1;

    // Randomised traffic
    for (int c = 0; c < 4000; c++) begin
      req = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom & $urandom & $urandom);
      en = ($urandom_range(0, 9) != 0);
      ready = ($urandom_range(0, 9) < 6);
      clr_ovr = ($urandom_range(0, 9) == 0);
      reset_b = ($urandom_range(0, 599) != 0);
      pe();
    end
    reset_b = 1'b1;
    pe();
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
